mac_result_encoder: RTL and testbench

Tail-end encoder of the SD4 MAC. It takes the signed fixed-point accumulator result, together with the group's max exponent and exponent bias, and packs it back into the 8-bit activation format that stage1 decodes: [7] sign, [6:3] 4-bit exponent, [2:0] mantissa with a hidden leading 1, and all-zero [6:0] meaning zero. Normalisation is iterative, one shift per cycle. The block uses a valid/ready handshake on both sides.

---
 rtl/mac_result_encoder_if.sv | 37 +++
 rtl/mac_result_encoder.sv | 178 +++++++++++++++++
 tb/tb_mac_result_encoder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_result_encoder_if.sv
// ============================================================================
// Module      : mac_result_encoder_if
// Description : Handshake bundle for the SD4 MAC result encoder.
//               Input side : in_valid/in_ready, acc_in, exp_max_in, exp_bias_in
//               Output side: out_valid/out_ready, image_out, ovf, unf
//               master = transaction source and result sink
//               slave  = the encoder itself
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_result_encoder_if #(
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc_in;
  logic [4:0]       exp_max_in;
  logic [4:0]       exp_bias_in;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       image_out;
  logic             ovf;
  logic             unf;

  modport master (
    output in_valid, acc_in, exp_max_in, exp_bias_in, out_ready,
    input  in_ready, out_valid, image_out, ovf, unf
  );

  modport slave (
    input  in_valid, acc_in, exp_max_in, exp_bias_in, out_ready,
    output in_ready, out_valid, image_out, ovf, unf
  );
endinterface

`default_nettype wire

// File: rtl/mac_result_encoder.sv
// ============================================================================
// Module      : mac_result_encoder
// Description : Packs a signed fixed-point accumulator result into the 8-bit
//               activation format {sign, exp[3:0], mant[2:0]} (hidden leading
//               one, all-zero [6:0] = zero). Normalisation shifts the
//               magnitude left one bit per cycle until the MSB is set.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-low reset
//               bus  - mac_result_encoder_if.slave (input and output
//                      valid/ready handshakes, operands, encoded result, flags)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_result_encoder #(
  parameter int ACC_W  = 12,
  parameter int FRAC_W = 6
) (
  input logic                clk,
  input logic                rst,
  mac_result_encoder_if.slave bus
);

  // Shift count never exceeds ACC_W-1, so clog2(ACC_W) bits hold it.
  localparam int CNT_W = $clog2(ACC_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_in_ready;
  logic             w_out_valid;

  logic             r_sign;
  logic [ACC_W-1:0] r_mag;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_exp_max;
  logic [4:0]       r_exp_bias;
  logic [7:0]       r_image;
  logic             r_ovf;
  logic             r_unf;

  logic [ACC_W-1:0] w_abs;
  logic [2:0]       w_mant;
  logic [7:0]       w_e;
  logic             w_e_neg;
  logic             w_e_big;

  // Two's complement magnitude; the most negative input maps to 2^(ACC_W-1),
  // which is still representable as an unsigned ACC_W-bit value.
  assign w_abs = bus.acc_in[ACC_W-1] ? (~bus.acc_in + ACC_W'(1)) : bus.acc_in;

  // Bits just below the leading one (which sits at the MSB after NORM).
  assign w_mant = r_mag[ACC_W-2:ACC_W-4];

  // e = exp_max + p - FRAC_W - exp_bias with p = ACC_W-1-cnt, in 8-bit
  // two's complement. Operand ranges keep the true value within +/-127.
  assign w_e = {3'b000, r_exp_max} + 8'(ACC_W - 1) - 8'(r_cnt)
             - 8'(FRAC_W) - {3'b000, r_exp_bias};
  assign w_e_neg = w_e[7];
  assign w_e_big = !w_e[7] && (w_e[6:4] != 3'b000);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = (w_abs == '0) ? PACK : NORM;
        end
      end
      NORM: begin
        if (r_mag[ACC_W-1]) begin
          w_state_next = PACK;
        end
      end
      PACK: begin
        w_state_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: capture, normalise, pack. The result registers are written only
  // in PACK so they hold their value through DONE and the following IDLE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sign     <= 1'b0;
      r_mag      <= '0;
      r_cnt      <= '0;
      r_exp_max  <= 5'd0;
      r_exp_bias <= 5'd0;
      r_image    <= 8'h00;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_sign     <= bus.acc_in[ACC_W-1];
            r_mag      <= w_abs;
            r_cnt      <= '0;
            r_exp_max  <= bus.exp_max_in;
            r_exp_bias <= bus.exp_bias_in;
          end
        end
        NORM: begin
          if (!r_mag[ACC_W-1]) begin
            r_mag <= r_mag << 1;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        PACK: begin
          if (r_mag == '0) begin
            r_image <= 8'h00;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
          end else if (w_e_big) begin
            r_image <= {r_sign, 4'hF, 3'b111};
            r_ovf   <= 1'b1;
            r_unf   <= 1'b0;
          end else if (w_e_neg || ((w_e == 8'd0) && (w_mant == 3'b000))) begin
            // e==0 with mant==0 would alias the zero encoding, so flush it.
            r_image <= 8'h00;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b1;
          end else begin
            r_image <= {r_sign, w_e[3:0], w_mant};
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.image_out = r_image;
  assign bus.ovf       = r_ovf;
  assign bus.unf       = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_mac_result_encoder.sv
// ============================================================================
// Module      : tb_mac_result_encoder
// Description : Self-checking bench for mac_result_encoder. A transaction
//               level model predicts the encoded image, flags and latency of
//               each accepted input; a negedge process compares every output
//               against it each cycle. Directed vectors add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_result_encoder;

  localparam int ACC_W  = 12;
  localparam int FRAC_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_result_encoder_if #(.ACC_W(ACC_W)) bus ();

  mac_result_encoder #(.ACC_W(ACC_W), .FRAC_W(FRAC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction model: result from plain integer arithmetic on the format.
  // --------------------------------------------------------------------------
  task automatic model(input logic [ACC_W-1:0] acc, input logic [4:0] em,
                       input logic [4:0] eb, output logic [7:0] img,
                       output logic o, output logic u, output int lat);
    int   a, mag, p, e, mant;
    logic s;
    a   = $signed(acc);
    s   = (a < 0);
    mag = s ? -a : a;
    img = 8'h00;
    o   = 1'b0;
    u   = 1'b0;
    if (mag == 0) begin
      lat = 1;
    end else begin
      p = 0;
      for (int i = 0; i < ACC_W; i++) if ((mag >> i) != 0) p = i;
      mant = (p >= 3) ? ((mag >> (p - 3)) & 7) : ((mag << (3 - p)) & 7);
      e    = int'(em) + p - FRAC_W - int'(eb);
      lat  = (ACC_W - 1 - p) + 2;
      if (e > 15) begin
        img = {s, 7'h7F};
        o   = 1'b1;
      end else if (e < 0 || (e == 0 && mant == 0)) begin
        u = 1'b1;
      end else begin
        img = {s, 4'(e), 3'(mant)};
      end
    end
  endtask

  bit         started = 1'b0;
  bit         busy    = 1'b0;
  int         cyc     = 0;
  int         acc_count = 0;
  logic [7:0] cur_img, last_img;
  logic       cur_ovf, cur_unf, last_ovf, last_unf;
  int         cur_lat;
  logic       exp_v;

  // Model state advances on each clock edge from the bench's own view of the
  // handshakes (never from DUT outputs).
  always @(posedge clk) begin
    if (!rst) begin
      started  = 1'b1;
      busy     = 1'b0;
      cyc      = 0;
      last_img = 8'h00;
      last_ovf = 1'b0;
      last_unf = 1'b0;
    end else if (started) begin
      if (busy) begin
        if (cyc >= cur_lat && bus.out_ready) begin
          busy     = 1'b0;
          last_img = cur_img;
          last_ovf = cur_ovf;
          last_unf = cur_unf;
        end else begin
          cyc = cyc + 1;
        end
      end else if (bus.in_valid) begin
        model(bus.acc_in, bus.exp_max_in, bus.exp_bias_in,
              cur_img, cur_ovf, cur_unf, cur_lat);
        busy      = 1'b1;
        cyc       = 0;
        acc_count = acc_count + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      exp_v = busy && (cyc >= cur_lat);
      chk("mon_in_ready",  32'(bus.in_ready),  32'(!busy));
      chk("mon_out_valid", 32'(bus.out_valid), 32'(exp_v));
      chk("mon_image",     32'(bus.image_out), 32'(exp_v ? cur_img : last_img));
      chk("mon_ovf",       32'(bus.ovf),       32'(exp_v ? cur_ovf : last_ovf));
      chk("mon_unf",       32'(bus.unf),       32'(exp_v ? cur_unf : last_unf));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic wait_accept();
    int n = 0;
    int start = acc_count;
    while (acc_count == start && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (acc_count == start) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL accept_timeout: input not taken within 50 cycles");
    end
  endtask

  task automatic send(input logic [ACC_W-1:0] acc, input logic [4:0] em, input logic [4:0] eb);
    @(negedge clk);
    bus.acc_in      = acc;
    bus.exp_max_in  = em;
    bus.exp_bias_in = eb;
    bus.in_valid    = 1'b1;
    wait_accept();
    bus.in_valid = 1'b0;
  endtask

  // Returns at the negedge where out_valid is first seen; lat = edges since accept.
  task automatic get_result(output logic [7:0] img, output logic o, output logic u, output int lat);
    int j = 0;
    @(negedge clk);
    while (!bus.out_valid && j < 60) begin
      j++;
      @(negedge clk);
    end
    if (!bus.out_valid) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL result_timeout: out_valid not seen within 60 cycles");
    end
    img = bus.image_out;
    o   = bus.ovf;
    u   = bus.unf;
    lat = j;
  endtask

  task automatic txn(input string nm, input logic [ACC_W-1:0] acc, input logic [4:0] em,
                     input logic [4:0] eb, input logic [7:0] x_img, input logic x_o,
                     input logic x_u, input int x_lat);
    logic [7:0] img;
    logic       o, u;
    int         lat;
    send(acc, em, eb);
    get_result(img, o, u, lat);
    chk({nm, "_img"}, 32'(img), 32'(x_img));
    chk({nm, "_ovf"}, 32'(o),   32'(x_o));
    chk({nm, "_unf"}, 32'(u),   32'(x_u));
    chk({nm, "_lat"}, 32'(lat), 32'(x_lat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] img;
    logic       o, u;
    int         lat;
    int         seen;

    rst             = 1'b0;
    bus.in_valid    = 1'b0;
    bus.acc_in      = '0;
    bus.exp_max_in  = 5'd0;
    bus.exp_bias_in = 5'd0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_image",     32'(bus.image_out), 32'h00);
    chk("rst_flags",     32'({bus.ovf, bus.unf}), 32'd0);

    //  name      acc      em     eb    image  ovf   unf   latency
    txn("pos64",  12'h040, 5'd8,  5'd0, 8'h40, 1'b0, 1'b0, 7);
    txn("neg72",  12'hFB8, 5'd8,  5'd2, 8'hB1, 1'b0, 1'b0, 7);
    txn("satpos", 12'h7FF, 5'd31, 5'd0, 8'h7F, 1'b1, 1'b0, 3);
    txn("mostng", 12'h800, 5'd4,  5'd0, 8'hC8, 1'b0, 1'b0, 2);
    txn("tiny",   12'h001, 5'd0,  5'd3, 8'h00, 1'b0, 1'b1, 13);
    txn("zero",   12'h000, 5'd8,  5'd0, 8'h00, 1'b0, 1'b0, 1);
    txn("e0m0",   12'h040, 5'd0,  5'd0, 8'h00, 1'b0, 1'b1, 7);
    txn("e0m1",   12'h048, 5'd0,  5'd0, 8'h01, 1'b0, 1'b0, 7);
    txn("e15",    12'h040, 5'd15, 5'd0, 8'h78, 1'b0, 1'b0, 7);
    txn("e16",    12'h040, 5'd16, 5'd0, 8'h7F, 1'b1, 1'b0, 7);
    txn("e16neg", 12'hFC0, 5'd16, 5'd0, 8'hFF, 1'b1, 1'b0, 7);

    // Backpressure: result must hold while a new input waits.
    bus.out_ready = 1'b0;
    send(12'h040, 5'd8, 5'd0);
    get_result(img, o, u, lat);
    chk("bp_img", 32'(img), 32'h40);
    chk("bp_lat", 32'(lat), 32'd7);
    bus.acc_in      = 12'h100;
    bus.exp_max_in  = 5'd8;
    bus.exp_bias_in = 5'd0;
    bus.in_valid    = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_img",   32'(bus.image_out), 32'h40);
      chk("bp_in_ready",   32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel_in_ready",  32'(bus.in_ready),  32'd1);
    chk("bp_rel_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_rel_img_held",  32'(bus.image_out), 32'h40);
    wait_accept();
    bus.in_valid = 1'b0;
    get_result(img, o, u, lat);
    chk("bp_next_img", 32'(img), 32'h50);
    chk("bp_next_lat", 32'(lat), 32'd5);
    @(posedge clk);
    #1;

    // Reset in the middle of normalisation.
    send(12'h001, 5'd0, 5'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_image",     32'(bus.image_out), 32'h00);
    chk("mid_rst_flags",     32'({bus.ovf, bus.unf}), 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("mid_rst_no_stale", 32'(seen), 32'd0);

    txn("recover", 12'hFB8, 5'd8, 5'd2, 8'hB1, 1'b0, 1'b0, 7);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
